// File: rtl/counter_uart_tx.sv
// UART 8N1 transmitter for the demo counter value, valid/ready byte input.
// Define UART_PARITY_EN to insert an even-parity bit after data bit 7.
module counter_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    data_q, data_d;
  logic          tx_q, tx_d;
  logic          done_q, done_d;

  logic          bit_end;
  logic [2:0]    bit_nx;
  logic          accept;

  assign in_ready = (state_q == S_IDLE) & ena;
  assign accept   = in_valid & in_ready;
  assign bit_end  = (cnt_q == CNT_LAST);
  assign bit_nx   = bit_q + 3'd1;

  assign tx   = tx_q;
  assign busy = (state_q != S_IDLE);
  assign done = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  // tx is registered: each transition loads the level of the next bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    data_d  = data_q;
    tx_d    = tx_q;
    done_d  = 1'b0;

    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CNT_ONE;
    end

    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (accept) begin
          data_d  = in_data;
          state_d = S_START;
          tx_d    = 1'b0;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
          tx_d    = data_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = S_PAR;
            tx_d    = ^data_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d = bit_nx;
            tx_d  = data_q[bit_nx];
          end
        end
      end
      S_PAR: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_counter_uart_tx.sv
// Scoreboard bench for counter_uart_tx: random bytes, line decoder monitor.
// Frame length follows UART_PARITY_EN.
module tb_counter_uart_tx;

  localparam int C = 4;
`ifdef UART_PARITY_EN
  localparam int F = 11;
`else
  localparam int F = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic       done;

  counter_uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .tx      (tx),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv,
               $time);
    end
  endtask

  // Reference model: a frame occupies F*C cycles after acceptance.
  logic [7:0] exp_q[$];
  int rem = 0;
  int acc_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem <= 0;
      exp_q.delete();
    end else if (rem > 0) begin
      rem <= rem - 1;
    end else if (in_valid && ena) begin
      rem <= F * C;
      exp_q.push_back(in_data);
      acc_cnt <= acc_cnt + 1;
    end
  end

  // Monitor: decode the line mid-bit, relative to the start-bit edge.
  bit         mact = 1'b0;
  int         mn = 0;
  int         mj;
  logic [7:0] mcur;
  logic [7:0] mgot;

  always @(negedge clk) begin
    if (!rst_n) begin
      mact = 1'b0;
    end else begin
      chk("in_ready", in_ready, (rem == 0 && ena));
      if (!mact) begin
        chk("idle_done", done, 1'b0);
        if (tx == 1'b0) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_start", 1'b1, 1'b0);
          end else begin
            mact = 1'b1;
            mn   = 0;
            mcur = exp_q[0];
            mgot = 8'h00;
            chk("start_busy", busy, 1'b1);
          end
        end else begin
          chk("idle_busy", busy, 1'b0);
        end
      end else begin
        mn++;
        if (mn % C == C / 2) begin
          mj = mn / C;
          if (mj == 0) begin
            chk("start_bit", tx, 1'b0);
          end else if (mj <= 8) begin
            mgot[mj-1] = tx;
            chk("data_bit", tx, mcur[mj-1]);
          end else if (mj == F - 1) begin
            chk("stop_bit", tx, 1'b1);
          end else begin
            chk("parity_bit", tx, ^mcur);
          end
        end
        if (mn == F * C - 1) begin
          chk("pre_done", done, 1'b0);
          chk("busy_end", busy, 1'b1);
        end
        if (mn == F * C) begin
          chk("done_pulse", done, 1'b1);
          chk("busy_clear", busy, 1'b0);
          chk("idle_gap", tx, 1'b1);
          chk("byte", mgot, exp_q.pop_front());
          mact = 1'b0;
        end
      end
    end
  end

  task automatic wait_acc();
    int a0;
    bit got;
    a0  = acc_cnt;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (acc_cnt > a0) got = 1'b1;
    end
    if (!got) chk("accept_timeout", 1'b0, 1'b1);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    in_data  = d;
    in_valid = 1'b1;
    wait_acc();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !mact) ok = 1'b1;
    end
    if (!ok) chk("drain_timeout", 1'b0, 1'b1);
    #1;
  endtask

  initial begin
    ena = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("rst_tx", tx, 1'b1);
      chk("rst_ready", in_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
    end
    rst_n = 1'b1;

    send(8'hA5);
    drain();

    in_data  = 8'h00;
    in_valid = 1'b1;
    wait_acc();
    in_data  = 8'hFF;
    wait_acc();
    in_valid = 1'b0;
    drain();

    in_data  = 8'h3C;
    in_valid = 1'b1;
    wait_acc();
    in_data  = 8'hC3;
    wait_acc();
    in_valid = 1'b0;
    drain();

    send(8'h55);
    repeat (16) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_tx", tx, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    send(8'h81);
    drain();

    ena      = 1'b0;
    in_data  = 8'h5A;
    in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      chk("ena_ready", in_ready, 1'b0);
      chk("ena_tx", tx, 1'b1);
      chk("ena_busy", busy, 1'b0);
    end
    in_valid = 1'b0;
    ena      = 1'b1;
    send(8'h07);
    drain();

    for (int it = 0; it < 40; it++) begin
      in_data  = 8'($urandom);
      in_valid = 1'($urandom);
      ena      = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(1, 60)) @(negedge clk);
      #1;
    end
    in_valid = 1'b0;
    ena      = 1'b1;
    drain();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
